// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
//   Shared definitions for the universal shift register.
//   - usr_mode_e : 3-bit operation select.
//   - cnt_w()    : width of the shift counter for a given register width.
//   - is_shift() : true for the modes that move bits and advance the counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } usr_mode_e;

  localparam int USR_MIN_WIDTH = 2;
  localparam int USR_MAX_WIDTH = 64;

  // Counter must hold 0..WIDTH-1; sized as $clog2(WIDTH+1) to match the port.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_shift(input usr_mode_e m);
    return m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR};
  endfunction

endpackage

// File: rtl/usr_mode_mux.sv
// -----------------------------------------------------------------------------
// usr_mode_mux
//   WIDTH-wide 8:1 next-state selector for the universal shift register.
//   Ports:
//     mode_i  : operation select (usr_mode_e)
//     q_i     : current register contents
//     pin_i   : parallel load data
//     sin_r_i : bit entering the MSB on a logical right shift
//     sin_l_i : bit entering the LSB on a logical left shift
//     d_o     : candidate next register value
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module usr_mode_mux
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_mode_e          mode_i,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   pin_i,
  input  logic               sin_r_i,
  input  logic               sin_l_i,
  output logic [WIDTH-1:0]   d_o
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives d_o;
    // a missing assignment in combinational logic infers a latch.
    d_o = q_i;
    unique case (mode_i)
      MODE_HOLD: d_o = q_i;
      MODE_SHR:  d_o = {sin_r_i, q_i[WIDTH-1:1]};
      MODE_SHL:  d_o = {q_i[WIDTH-2:0], sin_l_i};
      MODE_LOAD: d_o = pin_i;
      MODE_ROR:  d_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  d_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      // Arithmetic shift replicates the sign bit into the vacated MSB.
      MODE_ASR:  d_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_CLR:  d_o = '0;
      default:   d_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit shift register with hold, logical shift both ways, parallel
//   load, rotate both ways, arithmetic right shift and clear. A counter tracks
//   shifts since the last load/clear modulo WIDTH and word_done pulses for one
//   cycle each time a full word has been shifted.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : synchronous active-low reset
//     en        : operation enable (0 = hold everything)
//     mode      : operation select, see usr_pkg::usr_mode_e
//     sin_r     : serial in at MSB for right shift
//     sin_l     : serial in at LSB for left shift
//     pin       : parallel load data
//     q         : register contents
//     sout_r    : q[0], next bit out on a right shift
//     sout_l    : q[WIDTH-1], next bit out on a left shift
//     cnt       : shifts since last load/clear, modulo WIDTH
//     word_done : registered one-cycle pulse after each WIDTH-th shift
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       word_done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  usr_mode_e        mode_e;
  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] q_d,   q_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             word_done_d, word_done_q;
  logic             shift_op;

  assign mode_e   = usr_mode_e'(mode);
  assign shift_op = en && is_shift(mode_e);

  usr_mode_mux #(.WIDTH(WIDTH)) u_mux (
    .mode_i  (mode_e),
    .q_i     (q_q),
    .pin_i   (pin),
    .sin_r_i (sin_r),
    .sin_l_i (sin_l),
    .d_o     (mux_d)
  );

  always_comb begin
    q_d         = q_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    if (en) begin
      q_d = mux_d;
      if (shift_op) begin
        // Wrap at WIDTH-1 so back-to-back words pulse every WIDTH shifts.
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          word_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (mode_e == MODE_LOAD || mode_e == MODE_CLR) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      q_q         <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign q         = q_q;
  assign cnt       = cnt_q;
  assign word_done = word_done_q;
  assign sout_r    = q_q[0];
  assign sout_l    = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
`timescale 1ns/1ps
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, sin_r, sin_l;
  logic [2:0]   mode;
  logic [W-1:0] pin;
  logic [W-1:0] q;
  logic         sout_r, sout_l, word_done;
  logic [3:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state for the randomised phase.
  logic [W-1:0] mq;
  logic [3:0]   mcnt;
  logic         mwd;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .pin       (pin),
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .cnt       (cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input usr_mode_e m, input logic e);
    mode = m;
    en   = e;
    step();
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic [3:0] ec,
                         input logic ewd);
    check({tag, ".q"},   64'(q),         64'(eq));
    check({tag, ".cnt"}, 64'(cnt),       64'(ec));
    check({tag, ".wd"},  64'(word_done), 64'(ewd));
  endtask

  // Independent behavioural model built from shift operators.
  task automatic model_step();
    logic [W-1:0] nq;
    nq = mq;
    if (!rst_n) begin
      mq = '0; mcnt = '0; mwd = 1'b0;
    end else if (!en) begin
      mwd = 1'b0;
    end else begin
      case (mode)
        3'd1: nq = (mq >> 1) | {sin_r, 7'b0};
        3'd2: nq = (mq << 1) | {7'b0, sin_l};
        3'd3: nq = pin;
        3'd4: nq = (mq >> 1) | (mq << 7);
        3'd5: nq = (mq << 1) | (mq >> 7);
        3'd6: nq = (mq >> 1) | (mq & 8'h80);
        3'd7: nq = 8'h00;
        default: nq = mq;
      endcase
      mwd = 1'b0;
      if (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) begin
        if (mcnt == 4'd7) begin mcnt = 4'd0; mwd = 1'b1; end
        else mcnt = mcnt + 4'd1;
      end else if (mode == 3'd3 || mode == 3'd7) begin
        mcnt = 4'd0;
      end
      mq = nq;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = MODE_LOAD; sin_r = 1'b0; sin_l = 1'b0; pin = 8'hFF;

    // Reset dominates en/mode.
    step(); step();
    chk_all("reset", 8'h00, 4'd0, 1'b0);

    // Load and serial outputs.
    rst_n = 1'b1; pin = 8'hA5;
    op(MODE_LOAD, 1'b1);
    chk_all("load_a5", 8'hA5, 4'd0, 1'b0);
    check("load_a5.sout_r", 64'(sout_r), 64'(1));
    check("load_a5.sout_l", 64'(sout_l), 64'(1));

    // Each mode from a known value.
    sin_r = 1'b0; op(MODE_SHR, 1'b1);
    chk_all("shr", 8'h52, 4'd1, 1'b0);
    check("shr.sout_r", 64'(sout_r), 64'(0));
    check("shr.sout_l", 64'(sout_l), 64'(0));
    sin_l = 1'b1; op(MODE_SHL, 1'b1);
    chk_all("shl", 8'hA5, 4'd2, 1'b0);
    op(MODE_ROR, 1'b1);
    chk_all("ror", 8'hD2, 4'd3, 1'b0);
    op(MODE_ROL, 1'b1);
    chk_all("rol", 8'hA5, 4'd4, 1'b0);
    op(MODE_HOLD, 1'b1);
    chk_all("hold", 8'hA5, 4'd4, 1'b0);
    op(MODE_CLR, 1'b0);
    chk_all("en0_clr", 8'hA5, 4'd4, 1'b0);
    pin = 8'h80; op(MODE_LOAD, 1'b1);
    chk_all("load_80", 8'h80, 4'd0, 1'b0);
    op(MODE_ASR, 1'b1);
    chk_all("asr", 8'hC0, 4'd1, 1'b0);
    op(MODE_CLR, 1'b1);
    chk_all("clr", 8'h00, 4'd0, 1'b0);

    // 16 back-to-back rotates: pulses after shifts 8 and 16, none between.
    pin = 8'h81; op(MODE_LOAD, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      op(MODE_ROR, 1'b1);
      check($sformatf("ror16.cnt%0d", i), 64'(cnt), 64'(i % 8));
      check($sformatf("ror16.wd%0d", i), 64'(word_done), 64'(i == 8 || i == 16));
    end
    check("ror16.q", 64'(q), 64'h81);
    op(MODE_HOLD, 1'b1);
    check("ror16.wd_clear", 64'(word_done), 64'(0));

    // Enable gap freezes the count; direction change does not reset it.
    pin = 8'h00; op(MODE_LOAD, 1'b1);
    sin_l = 1'b1;
    op(MODE_SHL, 1'b1); op(MODE_SHL, 1'b1); op(MODE_SHL, 1'b1);
    chk_all("shl3", 8'h07, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      op(MODE_SHR, 1'b0);
      chk_all($sformatf("gap%0d", i), 8'h07, 4'd3, 1'b0);
    end
    sin_r = 1'b0;
    op(MODE_SHR, 1'b1); chk_all("shr_a", 8'h03, 4'd4, 1'b0);
    op(MODE_SHR, 1'b1); op(MODE_SHR, 1'b1); op(MODE_SHR, 1'b1);
    chk_all("shr_d", 8'h00, 4'd7, 1'b0);
    op(MODE_SHR, 1'b1); chk_all("shr_e", 8'h00, 4'd0, 1'b1);

    // Reset mid-word discards the partial count.
    pin = 8'hFF; op(MODE_LOAD, 1'b1);
    for (int i = 0; i < 5; i++) op(MODE_SHR, 1'b1);
    chk_all("pre_rst", 8'h07, 4'd5, 1'b0);
    rst_n = 1'b0; pin = 8'hAA; op(MODE_LOAD, 1'b1);
    chk_all("mid_rst", 8'h00, 4'd0, 1'b0);
    rst_n = 1'b1; sin_r = 1'b1; op(MODE_SHR, 1'b1);
    chk_all("post_rst", 8'h80, 4'd1, 1'b0);

    // Randomised run against the behavioural model.
    mq = q; mcnt = cnt; mwd = word_done;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 7) != 0);
      mode  = 3'($urandom_range(0, 7));
      sin_r = 1'($urandom_range(0, 1));
      sin_l = 1'($urandom_range(0, 1));
      pin   = 8'($urandom_range(0, 255));
      model_step();
      step();
      chk_all($sformatf("rnd%0d", i), mq, mcnt, mwd);
      check($sformatf("rnd%0d.sout_r", i), 64'(sout_r), 64'(mq[0]));
      check($sformatf("rnd%0d.sout_l", i), 64'(sout_l), 64'(mq[7]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
